// File: rtl/mux_n_1_pipe.sv
// N:1 registered multiplexer with valid/ready handshake.
// MODE=0 selects the channel named by sel; MODE=1 round-robins over the valid channels.
module mux_n_1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 2,
  parameter int MODE   = 0,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_src,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam logic [SEL_W:0]   NUM_IN_X = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              can_load;
  logic              pick_ok;
  logic [SEL_W-1:0]  pick_idx;
  logic [SEL_W:0]    cand;
  logic [WIDTH-1:0]  pick_data;
  logic              accept;

  assign can_load = !flush && (!out_valid_q || out_ready);

  // Candidate index is one bit wider so ptr+k never overflows before the explicit wrap.
  always_comb begin : choose
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    if (MODE == 1) begin
      for (int k = 0; k < NUM_IN; k++) begin
        cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
        if (cand >= NUM_IN_X) cand = cand - NUM_IN_X;
        if (!pick_ok && in_valid[cand[SEL_W-1:0]]) begin
          pick_ok  = 1'b1;
          pick_idx = cand[SEL_W-1:0];
        end
      end
    end else begin
      pick_ok  = ({1'b0, sel} < NUM_IN_X);
      pick_idx = sel;
    end
  end

  always_comb begin : route
    in_ready  = '0;
    pick_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == pick_idx) begin
        in_ready[i] = can_load && pick_ok && !rst;
        pick_data   = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = |(in_ready & in_valid);

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_data_d = pick_data;
      out_src_d  = pick_idx;
      if (MODE == 1) ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + SEL_W'(1);
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
